serial_adder: RTL and testbench
===============================

# serial_adder

- Parametrised digit-serial two's-complement adder/subtractor.
- Adds or subtracts two WIDTH-bit operands over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, with carry-in and carry-out.
- Reports signed overflow and uses a start/busy/done handshake.
- Successor to the single-bit combinational adder stage; used where area matters more than latency in the P-series datapath.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0: a+b+cin; 1: a−b−cin (computed as a+~b+~cin).
- cin  in  1  carry-in (borrow-in when sub=1).
- a, b  in  WIDTH  operands; captured on the accepting edge.
- sat  in  1  saturate on overflow (present only with SERIAL_ADDER_SAT_EN); captured with the operands.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when results are valid.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB; for sub, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN when start=1. On that edge:
  - latch a, ~b (if sub) or b, and sat;
  - set the carry register to cin^sub;
  - clear the digit counter and the sum shift register.
- RUN: each edge adds the lowest DIGIT bits of the operand registers and the carry register, then:
  - shifts the operand registers right by DIGIT;
  - shifts the result digit into the top of the sum register;
  - updates the carry;
  - increments the counter.
- After N=WIDTH/DIGIT digits, RUN→DONE. On the final digit:
  - cout = carry out of the MSB;
  - overflow = carry into the MSB XOR cout.
- DONE lasts exactly one cycle.
  - start=1 in DONE → RUN with new operands (back-to-back).
  - Otherwise → IDLE.
- start while in RUN is ignored; the operation is not restarted.
- sum, cout and overflow hold their last values until the next accepted start. They are not cleared on accept: they keep the previous result during RUN and update only on the final digit edge.
- Reset (rst_n=0 at any edge, including mid-RUN):
  - state←IDLE;
  - busy, done, sum, cout, overflow ← 0;
  - the operation in flight is discarded.
- Width rules: all arithmetic is modulo 2^WIDTH; the counter is ceil(log2(N+1)) bits.

## Timing
- Start accepted at edge E0. Digits are processed at edges E1..EN.
- busy=1 in the cycles after E0 through EN; done=1 only in the cycle after EN.
- Latency from accepted start to done: N+1 cycles (WIDTH=8, DIGIT=1 → 9; DIGIT=4 → 3).
- Throughput with back-to-back starts: one result per N+1 cycles.
- done and busy are never high in the same cycle.

## Configuration
- Macro: SERIAL_ADDER_SAT_EN.
- Defined:
  - the sat port exists;
  - if the latched sat=1 and overflow=1, sum is clamped to 2^(WIDTH−1)−1 on positive overflow (both operand MSBs 0 after inversion) or to −2^(WIDTH−1) on negative overflow;
  - overflow and cout still report the raw result.
- Undefined: no sat port; sum is always the wrapped result.

## Structure
- Shared package adder_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the saturation limit functions parameterised by width.
- Sub-module digit_adder (parameter DIGIT), combinational:
  - inputs x, y, ci;
  - outputs s[DIGIT], co, and c_msb (carry into its top bit, used for overflow).
- serial_adder instantiates one digit_adder and owns the FSM, counter and shift registers.

## Test plan
- WIDTH=8, DIGIT=1: a=8'h7F, b=8'h01, sub=0, cin=0 → after 9 cycles done=1, sum=8'h80, cout=0, overflow=1. With SERIAL_ADDER_SAT_EN and sat=1 → sum=8'h7F.
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, overflow=0.
- WIDTH=8, DIGIT=4, sub=1: a=8'h05, b=8'h07, cin=0 → done 3 cycles after start, sum=8'hFE, cout=0, overflow=0. Then a=8'h80, b=8'h01 → sum=8'h7F, overflow=1; with sat=1 → sum=8'h80.
- Back-to-back: start held high from cycle after done → second result valid N+1 cycles later. A start pulse mid-RUN → ignored, first result unchanged.
- Reset mid-RUN at digit 3 → next cycle busy=0, done=0, sum=0, cout=0, overflow=0. A new start then completes correctly: 8'h12+8'h34 → 8'h46.
- WIDTH=32, DIGIT=8, cin=1: a=32'hFFFF_FFFF, b=32'h0 → sum=32'h0, cout=1, overflow=0, done 5 cycles after start.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared state encoding and saturation limits for the digit-serial adder.
// Limits are computed at MAX_WIDTH bits; callers keep the low WIDTH bits.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Largest positive two's-complement value of width w: 0111...1
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int w);
    sat_max = (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
  endfunction

  // Most negative two's-complement value of width w: 1000...0
  function automatic logic [MAX_WIDTH-1:0] sat_min(input int w);
    sat_min = MAX_WIDTH'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; zero latency, no backpressure.
// c_msb is the carry into the top bit, exposed for signed-overflow detection.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  always_comb begin : chain
    logic c;
    c     = ci;
    s     = '0;
    c_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/sub: start->done latency WIDTH/DIGIT+1 cycles; optional SERIAL_ADDER_SAT_EN clamps on overflow.
// No backpressure: start is ignored while busy, done is a one-cycle pulse.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [MAX_WIDTH-1:0] SMAX = sat_max(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SMIN = sat_min(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt, res;
  logic             carry;
  logic [DIGIT-1:0] d_s;
  logic             d_co, d_cm;
  logic             accept, last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (opa[DIGIT-1:0]),
    .y     (opb[DIGIT-1:0]),
    .ci    (carry),
    .s     (d_s),
    .co    (d_co),
    .c_msb (d_cm)
  );

  // New digit enters at the top; after N digits the first one reaches bit 0.
  assign acc_nxt = (acc >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_SAT_EN
  logic sat_q;

  // On the last digit opa/opb[DIGIT-1] are the operand sign bits.
  always_comb begin
    res = acc_nxt;
    if (sat_q && (d_cm ^ d_co))
      res = opa[DIGIT-1] ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0];
  end
`else
  assign res = acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
`ifdef SERIAL_ADDER_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
      acc   <= '0;
`ifdef SERIAL_ADDER_SAT_EN
      sat_q <= sat;
`endif
    end else if (state == RUN) begin
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      acc   <= acc_nxt;
      carry <= d_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum      <= res;
        cout     <= d_co;
        overflow <= d_cm ^ d_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 32/8), scoreboard per instance.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        s1_start, s1_sub, s1_cin, s1_sat, s1_busy, s1_done, s1_cout, s1_ovf;
  logic [7:0]  s1_a, s1_b, s1_sum;
  logic        s4_start, s4_sub, s4_cin, s4_sat, s4_busy, s4_done, s4_cout, s4_ovf;
  logic [7:0]  s4_a, s4_b, s4_sum;
  logic        s32_start, s32_sub, s32_cin, s32_sat, s32_busy, s32_done, s32_cout, s32_ovf;
  logic [31:0] s32_a, s32_b, s32_sum;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .cin(s1_cin),
    .a(s1_a), .b(s1_b),
`ifdef SERIAL_ADDER_SAT_EN
    .sat(s1_sat),
`endif
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .overflow(s1_ovf));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .cin(s4_cin),
    .a(s4_a), .b(s4_b),
`ifdef SERIAL_ADDER_SAT_EN
    .sat(s4_sat),
`endif
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout), .overflow(s4_ovf));

  serial_adder #(.WIDTH(32), .DIGIT(8)) u32 (
    .clk(clk), .rst_n(rst_n), .start(s32_start), .sub(s32_sub), .cin(s32_cin),
    .a(s32_a), .b(s32_b),
`ifdef SERIAL_ADDER_SAT_EN
    .sat(s32_sat),
`endif
    .busy(s32_busy), .done(s32_done), .sum(s32_sum), .cout(s32_cout), .overflow(s32_ovf));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    longint      t;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q32[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int ndig(input int sel);
    return (sel == 1) ? 8 : (sel == 4) ? 2 : 4;
  endfunction

  task automatic check_out(input int sel, input logic [31:0] s, input logic c, input logic o,
                           input logic bsy);
    exp_t  e;
    bit    have;
    string tag;
    tag  = $sformatf("u%0d", sel);
    have = 1'b0;
    case (sel)
      1:       if (q1.size()  > 0) begin e = q1.pop_front();  have = 1'b1; end
      4:       if (q4.size()  > 0) begin e = q4.pop_front();  have = 1'b1; end
      default: if (q32.size() > 0) begin e = q32.pop_front(); have = 1'b1; end
    endcase
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s_spurious_done: actual=done required=no_done", tag);
      return;
    end
    cmp({tag, "_sum"},  s, e.sum);
    cmp({tag, "_cout"}, {31'b0, c}, {31'b0, e.cout});
    cmp({tag, "_ovf"},  {31'b0, o}, {31'b0, e.ovf});
    cmp({tag, "_busy_with_done"}, {31'b0, bsy}, 32'd0);
    cmp({tag, "_latency_time"}, 32'($time), 32'(e.t));
  endtask

  always @(negedge clk) if (s1_done === 1'b1)  check_out(1,  {24'h0, s1_sum}, s1_cout, s1_ovf, s1_busy);
  always @(negedge clk) if (s4_done === 1'b1)  check_out(4,  {24'h0, s4_sum}, s4_cout, s4_ovf, s4_busy);
  always @(negedge clk) if (s32_done === 1'b1) check_out(32, s32_sum, s32_cout, s32_ovf, s32_busy);

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1:       s1_start  = v;
      4:       s4_start  = v;
      default: s32_start = v;
    endcase
  endtask

  task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin, input logic sat);
    case (sel)
      1:       begin s1_a = a[7:0]; s1_b = b[7:0]; s1_sub = sub; s1_cin = cin; s1_sat = sat; end
      4:       begin s4_a = a[7:0]; s4_b = b[7:0]; s4_sub = sub; s4_cin = cin; s4_sat = sat; end
      default: begin s32_a = a; s32_b = b; s32_sub = sub; s32_cin = cin; s32_sat = sat; end
    endcase
    set_start(sel, 1'b1);
  endtask

  // Drive from the current negedge; acceptance happens at the following posedge.
  task automatic issue_now(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin, input logic sat, input bit push,
                           input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    drive(sel, a, b, sub, cin, sat);
    if (push) begin
      e.sum = es; e.cout = ec; e.ovf = eo;
      e.t   = longint'($time) + 10 * (ndig(sel) + 1);
      case (sel)
        1:       q1.push_back(e);
        4:       q4.push_back(e);
        default: q32.push_back(e);
      endcase
    end
    @(posedge clk);
    #1 set_start(sel, 1'b0);
  endtask

  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin, input logic sat, input bit push,
                       input logic [31:0] es, input logic ec, input logic eo);
    @(negedge clk);
    issue_now(sel, a, b, sub, cin, sat, push, es, ec, eo);
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 1) ? s1_busy : (sel == 4) ? s4_busy : s32_busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 1) ? s1_done : (sel == 4) ? s4_done : s32_done;
  endfunction

  task automatic wait_done(input int sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_done(sel) === 1'b1) return;
    end
    total++; bad++;
    $display("FAIL u%0d_wait_done: actual=timeout required=done", sel);
  endtask

  task automatic wait_quiet(input int sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_busy(sel) === 1'b0 && get_done(sel) === 1'b0) return;
    end
    total++; bad++;
    $display("FAIL u%0d_wait_idle: actual=timeout required=idle", sel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {s1_start, s1_sub, s1_cin, s1_sat, s1_a, s1_b} = '0;
    {s4_start, s4_sub, s4_cin, s4_sat, s4_a, s4_b} = '0;
    {s32_start, s32_sub, s32_cin, s32_sat, s32_a, s32_b} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_u1_busy", {31'b0, s1_busy}, 32'd0);
    cmp("rst_u1_done", {31'b0, s1_done}, 32'd0);
    cmp("rst_u1_sum", {24'b0, s1_sum}, 32'd0);
    cmp("rst_u1_cout", {31'b0, s1_cout}, 32'd0);
    cmp("rst_u1_ovf", {31'b0, s1_ovf}, 32'd0);
    cmp("rst_u4_busy", {31'b0, s4_busy}, 32'd0);
    cmp("rst_u32_done", {31'b0, s32_done}, 32'd0);
    cmp("rst_u32_sum", s32_sum, 32'd0);
    rst_n = 1'b1;

    // WIDTH=8, DIGIT=1
    issue(1, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1, 1'b1, SAT ? 32'h7F : 32'h80, 1'b0, 1'b1);
    wait_quiet(1);
    issue(1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0);
    wait_quiet(1);
    issue(1, 32'h10, 32'h03, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0D, 1'b1, 1'b0);
    wait_quiet(1);
    issue(1, 32'h10, 32'h03, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 1'b0);
    wait_quiet(1);
    issue(1, 32'h80, 32'hFF, 1'b0, 1'b0, 1'b1, 1'b1, SAT ? 32'h80 : 32'h7F, 1'b1, 1'b1);
    wait_quiet(1);

    // Start pulse mid-RUN must be ignored; previous sum must hold during RUN
    issue(1, 32'h20, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    cmp("u1_sum_hold_in_run", {24'b0, s1_sum}, SAT ? 32'h80 : 32'h7F);
    cmp("u1_busy_in_run", {31'b0, s1_busy}, 32'd1);
    drive(1, 32'hFF, 32'hFF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    wait_quiet(1);

    // WIDTH=8, DIGIT=4
    issue(4, 32'h05, 32'h07, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0);
    wait_quiet(4);
    issue(4, 32'h80, 32'h01, 1'b1, 1'b0, 1'b1, 1'b1, SAT ? 32'h80 : 32'h7F, 1'b1, 1'b1);
    wait_quiet(4);

    // Back-to-back: second start presented during the DONE cycle
    issue(4, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0, 1'b1, 32'h46, 1'b0, 1'b0);
    wait_done(4);
    issue_now(4, 32'h0F, 32'hF1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0);
    wait_quiet(4);

    // WIDTH=32, DIGIT=8
    issue(32, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    wait_quiet(32);

    // Reset during digit 3, then a fresh operation
    issue(1, 32'h55, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cmp("midrst_busy", {31'b0, s1_busy}, 32'd0);
    cmp("midrst_done", {31'b0, s1_done}, 32'd0);
    cmp("midrst_sum", {24'b0, s1_sum}, 32'd0);
    cmp("midrst_cout", {31'b0, s1_cout}, 32'd0);
    cmp("midrst_ovf", {31'b0, s1_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0, 1'b1, 32'h46, 1'b0, 1'b0);
    wait_quiet(1);

    repeat (2) @(negedge clk);
    cmp("u1_results_outstanding", q1.size(), 32'd0);
    cmp("u4_results_outstanding", q4.size(), 32'd0);
    cmp("u32_results_outstanding", q32.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
